// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction prefetch stage.
package if_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WORD_ADDR_W = 30;

  localparam logic [WORD_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchReq,
    FetchAccess
  } fetch_state_e;

  // Extracts the slave-index field (top idx_w bits of an addr_w-bit word address).
  function automatic logic [31:0] slave_idx(input logic [63:0]   addr,
                                            input int unsigned   addr_w,
                                            input int unsigned   idx_w);
    logic [63:0] field;
    field = (addr >> (addr_w - idx_w)) & ((64'd1 << idx_w) - 64'd1);
    return field[31:0];
  endfunction

endpackage

// File: rtl/if_queue.sv
// Prefetch FIFO of {pc, insn} entries; pointers carry an extra wrap bit.
module if_queue #(
  parameter int unsigned Width = 62,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wptr_q, rptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PtrW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch stage: runs a fetch pointer ahead of ID, filling a small queue from
// the single-cycle SPM or the shared bus, and drives the IF/ID register from the queue head.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned       DATA_W   = WORD_W,
  parameter int unsigned       ADDR_W   = WORD_ADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       IDX_W    = 3,
  parameter int unsigned       SPM_IDX  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              busy,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy,
  input  logic              bus_grnt,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fpc_q, if_pc_q, bus_addr_q;
  logic [DATA_W-1:0] if_insn_q;
  logic              if_en_q, bus_req_q, bus_as_q, discard_q;

  logic              redirect, spm_hit, fetch_ok, bus_done, bus_push;
  logic [ADDR_W-1:0] redirect_pc, head_pc;
  logic [DATA_W-1:0] head_insn;
  logic              q_push, q_pop, q_full, q_empty;
  logic [EntW-1:0]   q_wdata, q_rdata;
  logic [CntW-1:0]   q_count;

  assign redirect    = !stall && (flush || br_taken);
  assign redirect_pc = flush ? new_pc : br_addr;
  assign spm_hit     = (slave_idx(64'(fpc_q), ADDR_W, IDX_W) == SPM_IDX);

  // A new fetch may start only from IDLE with room judged on the registered count.
  assign fetch_ok = rst && (state_q == FetchIdle) && (q_count != CntW'(DEPTH)) && !redirect;
  assign spm_as   = fetch_ok && spm_hit;
  assign spm_addr = fpc_q;

  assign bus_done = (state_q == FetchAccess) && bus_rdy;
  assign bus_push = bus_done && !discard_q && !redirect && !q_full;

  assign q_push  = spm_as || bus_push;
  assign q_wdata = spm_as ? {fpc_q, spm_rd_data} : {bus_addr_q, bus_rd_data};
  assign q_pop   = !stall && !redirect && !q_empty;
  assign {head_pc, head_insn} = q_rdata;

  if_queue #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FetchIdle;
      fpc_q      <= RESET_PC;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      bus_as_q   <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      if (redirect)    fpc_q <= redirect_pc;
      else if (q_push) fpc_q <= fpc_q + ADDR_W'(1);

      unique case (state_q)
        FetchIdle: begin
          if (fetch_ok && !spm_hit) begin
            state_q    <= FetchReq;
            bus_req_q  <= 1'b1;
            bus_addr_q <= fpc_q;
          end
        end
        FetchReq: begin
          // A grant wins over a same-cycle redirect; the data is then discarded.
          if (bus_grnt) begin
            state_q   <= FetchAccess;
            bus_as_q  <= 1'b1;
            discard_q <= redirect;
          end else if (redirect) begin
            state_q    <= FetchIdle;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
          end
        end
        FetchAccess: begin
          bus_as_q <= 1'b0;
          if (bus_rdy) begin
            state_q    <= FetchIdle;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            discard_q  <= 1'b0;
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= FetchIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc_q   <= RESET_PC;
      if_insn_q <= DATA_W'(NOP);
      if_en_q   <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        if_pc_q   <= redirect_pc;
        if_insn_q <= DATA_W'(NOP);
        if_en_q   <= 1'b0;
      end else if (!q_empty) begin
        if_pc_q   <= head_pc;
        if_insn_q <= head_insn;
        if_en_q   <= 1'b1;
      end else begin
        if_insn_q <= DATA_W'(NOP);
        if_en_q   <= 1'b0;
      end
    end
  end

  assign busy     = q_empty && (state_q != FetchIdle);
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;
  assign bus_as   = bus_as_q;
  assign bus_rw   = 1'b0;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: table-driven SPM streaming/stall plus hand sequences
// for bus handshake, redirects, address wrap and asynchronous reset.
module tb_if_prefetch;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam logic [AW-1:0] RPC = 10'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [AW-1:0] new_pc = '0, br_addr = '0;
  logic          busy;
  logic [DW-1:0] spm_rd_data;
  logic [AW-1:0] spm_addr;
  logic          spm_as;
  logic [DW-1:0] bus_rd_data = 32'hDEAD_BEEF;
  logic          bus_rdy = 1'b0, bus_grnt = 1'b0;
  logic          bus_req, bus_as, bus_rw, if_en;
  logic [AW-1:0] bus_addr, if_pc;
  logic [DW-1:0] if_insn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] spm_word(input logic [AW-1:0] a);
    return 32'h5A00_0000 | 32'(a);
  endfunction

  function automatic logic [DW-1:0] bus_word(input logic [AW-1:0] a);
    return 32'hB000_0000 | 32'(a);
  endfunction

  assign spm_rd_data = spm_word(spm_addr);

  if_prefetch #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (4),
    .IDX_W    (2),
    .SPM_IDX  (1),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .busy        (busy),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as      (spm_as),
    .bus_rd_data (bus_rd_data),
    .bus_rdy     (bus_rdy),
    .bus_grnt    (bus_grnt),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_as      (bus_as),
    .bus_rw      (bus_rw),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          stall;
    logic          spm_as;
    logic [AW-1:0] spm_addr;
    logic          en;
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic [AW-1:0] sa,
                              input logic e, input logic [AW-1:0] pc);
    vec_t v;
    v.stall    = s;
    v.spm_as   = a;
    v.spm_addr = sa;
    v.en       = e;
    v.pc       = pc;
    v.insn     = e ? spm_word(pc) : '0;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    // Streaming from reset, then 6 stalled cycles filling the queue, then release.
    vecs[0]  = mk(0, 1, 10'h100, 0, 10'h100);
    vecs[1]  = mk(0, 1, 10'h101, 1, 10'h100);
    vecs[2]  = mk(0, 1, 10'h102, 1, 10'h101);
    vecs[3]  = mk(0, 1, 10'h103, 1, 10'h102);
    vecs[4]  = mk(1, 1, 10'h104, 1, 10'h102);
    vecs[5]  = mk(1, 1, 10'h105, 1, 10'h102);
    vecs[6]  = mk(1, 1, 10'h106, 1, 10'h102);
    vecs[7]  = mk(1, 0, 10'h107, 1, 10'h102);
    vecs[8]  = mk(1, 0, 10'h107, 1, 10'h102);
    vecs[9]  = mk(1, 0, 10'h107, 1, 10'h102);
    vecs[10] = mk(0, 0, 10'h107, 1, 10'h103);
    vecs[11] = mk(0, 1, 10'h107, 1, 10'h104);
    vecs[12] = mk(0, 1, 10'h108, 1, 10'h105);
    vecs[13] = mk(0, 1, 10'h109, 1, 10'h106);
    vecs[14] = mk(0, 1, 10'h10A, 1, 10'h107);

    #12;
    check("rst.if_pc", 32'(if_pc), 32'(RPC));
    check("rst.if_en", 32'(if_en), 0);
    check("rst.if_insn", if_insn, 0);
    check("rst.bus_req", 32'(bus_req), 0);
    check("rst.bus_as", 32'(bus_as), 0);
    check("rst.bus_addr", 32'(bus_addr), 0);
    check("rst.bus_rw", 32'(bus_rw), 0);
    check("rst.spm_as", 32'(spm_as), 0);
    check("rst.busy", 32'(busy), 0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall;
      #1;
      check($sformatf("v%0d.spm_as", i), 32'(spm_as), 32'(vecs[i].spm_as));
      check($sformatf("v%0d.spm_addr", i), 32'(spm_addr), 32'(vecs[i].spm_addr));
      tick();
      check($sformatf("v%0d.if_en", i), 32'(if_en), 32'(vecs[i].en));
      check($sformatf("v%0d.if_pc", i), 32'(if_pc), 32'(vecs[i].pc));
      check($sformatf("v%0d.if_insn", i), if_insn, vecs[i].insn);
    end
    stall = 1'b0;

    // flush and br_taken together: flush wins, queue discarded.
    flush = 1'b1; br_taken = 1'b1; new_pc = 10'h040; br_addr = 10'h200;
    #1;
    check("both.spm_as", 32'(spm_as), 0);
    tick();
    flush = 1'b0; br_taken = 1'b0;
    check("both.if_pc", 32'(if_pc), 32'h040);
    check("both.if_en", 32'(if_en), 0);
    check("both.if_insn", if_insn, 0);
    check("both.busy", 32'(busy), 0);
    tick();
    check("b40.bus_req", 32'(bus_req), 1);
    check("b40.bus_addr", 32'(bus_addr), 32'h040);
    check("b40.busy", 32'(busy), 1);
    check("b40.if_en", 32'(if_en), 0);

    // Grant after 2 wait cycles, rdy after 3.
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("gw%0d.bus_as", i), 32'(bus_as), 0);
      check($sformatf("gw%0d.busy", i), 32'(busy), 1);
    end
    bus_grnt = 1'b1;
    tick();
    bus_grnt = 1'b0;
    check("grant.bus_as", 32'(bus_as), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rw%0d.bus_as", i), 32'(bus_as), 0);
      check($sformatf("rw%0d.busy", i), 32'(busy), 1);
      check($sformatf("rw%0d.if_en", i), 32'(if_en), 0);
    end
    bus_rdy = 1'b1; bus_rd_data = bus_word(10'h040);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    check("rdy.bus_req", 32'(bus_req), 0);
    check("rdy.bus_addr", 32'(bus_addr), 0);
    check("rdy.if_en", 32'(if_en), 0);
    check("rdy.busy", 32'(busy), 0);
    tick();
    check("bpop.if_en", 32'(if_en), 1);
    check("bpop.if_pc", 32'(if_pc), 32'h040);
    check("bpop.if_insn", if_insn, bus_word(10'h040));
    check("bpop.bus_addr", 32'(bus_addr), 32'h041);

    // Branch during ACCESS: in-flight word for 0x041 must be dropped.
    bus_grnt = 1'b1;
    tick();
    bus_grnt = 1'b0;
    check("acc.bus_as", 32'(bus_as), 1);
    br_taken = 1'b1; br_addr = 10'h200;
    tick();
    br_taken = 1'b0;
    check("br.if_pc", 32'(if_pc), 32'h200);
    check("br.if_en", 32'(if_en), 0);
    bus_rdy = 1'b1; bus_rd_data = bus_word(10'h041);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    check("disc.bus_req", 32'(bus_req), 0);
    check("disc.if_en", 32'(if_en), 0);
    check("disc.busy", 32'(busy), 0);
    tick();
    check("b200.if_en", 32'(if_en), 0);
    check("b200.bus_req", 32'(bus_req), 1);
    check("b200.bus_addr", 32'(bus_addr), 32'h200);
    bus_grnt = 1'b1;
    tick();
    bus_grnt = 1'b0;
    bus_rdy = 1'b1; bus_rd_data = bus_word(10'h200);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    check("b200r.if_en", 32'(if_en), 0);
    tick();
    check("b200p.if_en", 32'(if_en), 1);
    check("b200p.if_pc", 32'(if_pc), 32'h200);
    check("b200p.if_insn", if_insn, bus_word(10'h200));

    // Flush while requesting (not granted), then fetch at all-ones and wrap to 0.
    flush = 1'b1; new_pc = 10'h3FF;
    tick();
    flush = 1'b0;
    check("fr.bus_req", 32'(bus_req), 0);
    check("fr.if_pc", 32'(if_pc), 32'h3FF);
    check("fr.if_en", 32'(if_en), 0);
    tick();
    check("wrap.bus_addr0", 32'(bus_addr), 32'h3FF);
    bus_grnt = 1'b1;
    tick();
    bus_grnt = 1'b0;
    bus_rdy = 1'b1; bus_rd_data = bus_word(10'h3FF);
    tick();
    bus_rdy = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    tick();
    check("wrap.if_en", 32'(if_en), 1);
    check("wrap.if_pc", 32'(if_pc), 32'h3FF);
    check("wrap.if_insn", if_insn, bus_word(10'h3FF));
    check("wrap.bus_req", 32'(bus_req), 1);
    check("wrap.bus_addr1", 32'(bus_addr), 0);

    // Asynchronous reset in the middle of a REQ cycle.
    #2;
    rst = 1'b0;
    #1;
    check("arst.bus_req", 32'(bus_req), 0);
    check("arst.bus_as", 32'(bus_as), 0);
    check("arst.bus_addr", 32'(bus_addr), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.if_pc", 32'(if_pc), 32'(RPC));
    check("arst.if_en", 32'(if_en), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel.spm_as", 32'(spm_as), 1);
    check("rel.spm_addr", 32'(spm_addr), 32'(RPC));
    tick();
    tick();
    check("rel.if_en", 32'(if_en), 1);
    check("rel.if_pc", 32'(if_pc), 32'(RPC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
